// File: rtl/pipelined_segmented_adder.sv
// pipelined_segmented_adder
//   N-bit adder (a + b + ci) split into K = N/S segments, one segment per
//   pipeline stage, with the inter-segment carry registered between stages.
//   Operand segments not yet consumed ride along with the beat (input skew),
//   and finished sum segments are carried forward (output deskew), so the
//   final stage holds the complete sum. Latency is K cycles.
//   Backpressure stalls the whole pipe: en = ~out_valid | out_ready.
//
// Parameters
//   N : operand / result width
//   S : segment width (N must be a multiple of S)
//
// Ports
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset, discards in-flight beats
//   in_valid  : operand beat valid
//   in_ready  : block can accept a beat this cycle
//   a, b, ci  : operands and carry-in
//   out_valid : result beat valid
//   out_ready : downstream accepts result
//   c, co     : sum (mod 2^N) and carry-out of bit N-1
//   ov        : signed overflow, present only with
//               PIPELINED_SEGMENTED_ADDER_OVERFLOW_EN defined
module pipelined_segmented_adder #(
  parameter int N = 32,
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         co
`ifdef PIPELINED_SEGMENTED_ADDER_OVERFLOW_EN
  ,
  output logic         ov
`endif
);

  localparam int K = N / S;

  generate
    if (N % S != 0) begin : g_bad_cfg
      $error("pipelined_segmented_adder: N must be a multiple of S");
    end
  endgenerate

  // Stage k registers: full-width operand copy, partially built sum,
  // segment carry-out and valid.
  logic [N-1:0] a_q   [K];
  logic [N-1:0] b_q   [K];
  logic [N-1:0] sum_q [K];
  logic         cy_q  [K];
  logic         vld_q [K];

  // Stage k inputs: stage 0 is fed from the ports, stage k from stage k-1.
  logic [N-1:0] ain     [K];
  logic [N-1:0] bin     [K];
  logic         vin     [K];
  logic         cy_in   [K];
  logic [S:0]   seg_add [K];
  logic [N-1:0] sum_nxt [K];

  logic en;

  assign en        = ~vld_q[K-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[K-1];
  assign c         = sum_q[K-1];
  assign co        = cy_q[K-1];

  always_comb begin
    ain[0]     = a;
    bin[0]     = b;
    vin[0]     = in_valid;
    cy_in[0]   = ci;
    sum_nxt[0] = '0;
    for (int k = 1; k < K; k++) begin
      ain[k]     = a_q[k-1];
      bin[k]     = b_q[k-1];
      vin[k]     = vld_q[k-1];
      cy_in[k]   = cy_q[k-1];
      sum_nxt[k] = sum_q[k-1];
    end
    for (int k = 0; k < K; k++) begin
      seg_add[k] = {1'b0, ain[k][k*S +: S]} + {1'b0, bin[k][k*S +: S]}
                 + {{S{1'b0}}, cy_in[k]};
      sum_nxt[k][k*S +: S] = seg_add[k][S-1:0];
    end
  end

  // Data registers load only behind a valid beat; bubbles just move the
  // valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < K; k++) begin
        vld_q[k] <= vin[k];
        if (vin[k]) begin
          cy_q[k]  <= seg_add[k][S];
          sum_q[k] <= sum_nxt[k];
          a_q[k]   <= ain[k];
          b_q[k]   <= bin[k];
        end
      end
    end
  end

`ifdef PIPELINED_SEGMENTED_ADDER_OVERFLOW_EN
  // Carry into bit N-1 is recovered as a ^ b ^ sum at that bit.
  logic ov_nxt;
  logic ov_q;

  assign ov_nxt = ain[K-1][N-1] ^ bin[K-1][N-1] ^ seg_add[K-1][S-1]
                ^ seg_add[K-1][S];
  assign ov     = ov_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
    end else if (en && vin[K-1]) begin
      ov_q <= ov_nxt;
    end
  end
`endif

  // The last stage's operand copy has no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[K-1], b_q[K-1]};

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
module tb_pipelined_segmented_adder;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        co;
`ifdef PIPELINED_SEGMENTED_ADDER_OVERFLOW_EN
  logic        ov;
`endif

  pipelined_segmented_adder #(.N(32), .S(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .co        (co)
`ifdef PIPELINED_SEGMENTED_ADDER_OVERFLOW_EN
    ,
    .ov        (ov)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] c;
    logic        co;
  } vec_t;

  typedef struct {
    logic [31:0] c;
    logic        co;
    logic        ov;
    int          acc;
  } sb_t;

  sb_t  sbq[$];
  vec_t vt[10];
  logic [31:0] bpa[6];
  logic [31:0] bpb[6];

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_out = 0;
  logic acc_flag = 1'b0;
  logic chk_lat = 1'b0;

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic z);
    return {1'b0, x} + {1'b0, y} + {32'b0, z};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive after the falling edge, then evaluate the
  // handshakes that the next rising edge will act on.
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ici, input logic ordy, input logic [32:0] iexp);
    sb_t e;
    sb_t h;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    ci        = ici;
    out_ready = ordy;
    #1;
    acc_flag = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got c=%0h co=%0b with no beat outstanding", c, co);
      end else begin
        h = sbq.pop_front();
        chk("sum_c", 64'(c), 64'(h.c));
        chk("sum_co", 64'(co), 64'(h.co));
`ifdef PIPELINED_SEGMENTED_ADDER_OVERFLOW_EN
        chk("sum_ov", 64'(ov), 64'(h.ov));
`endif
        if (chk_lat) chk("latency", 64'(cyc - h.acc), 64'(K));
      end
    end
    if (acc_flag) begin
      e.c   = iexp[31:0];
      e.co  = iexp[32];
      e.ov  = (ia[31] == ib[31]) && (iexp[31] != ia[31]);
      e.acc = cyc;
      sbq.push_back(e);
    end
    cyc++;
  endtask

  task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic ici);
    int g;
    g = 0;
    do begin
      cycle(1'b1, ia, ib, ici, 1'b1, model(ia, ib, ici));
      g++;
    end while (!acc_flag && g < 50);
    if (!acc_flag) begin
      n_chk++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", g);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() > 0 && g < 40) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 33'h0);
      g++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int n0;
    int n_sent;
    int guard;
    logic [32:0] hold;
    logic iv;
    logic ordy;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rci;

    vt[0] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vt[1] = '{32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 1'b0};
    vt[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vt[3] = '{32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0};
    vt[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
    vt[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vt[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vt[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
    vt[8] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    vt[9] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
    bpa = '{32'h10000001, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00000080, 32'hDEADBEEF, 32'h00FFFFFF};
    bpb = '{32'h20000002, 32'h00010000, 32'hF0F0F0F1, 32'h00000080, 32'h21524111, 32'h00000001};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPELINED_SEGMENTED_ADDER_OVERFLOW_EN
    chk("rst_ov", 64'(ov), 64'd0);
`endif
    rst = 1'b0;

    // Carry through every segment, single beat, latency K.
    chk_lat = 1'b1;
    n0 = n_out;
    cycle(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 33'h1_0000_0000);
    chk("carry_accept", 64'(acc_flag), 64'd1);
    repeat (8) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 33'h0);
    chk("carry_one_beat", 64'(n_out - n0), 64'd1);

    // Table stream, back to back.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vt[i].a, vt[i].b, vt[i].ci, 1'b1, {vt[i].co, vt[i].c});
      chk("tbl_accept", 64'(acc_flag), 64'd1);
    end
    drain();

    // Backpressure: stall head for 5 cycles, then release.
    chk_lat = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 4; i++) cycle(1'b1, bpa[i], bpb[i], 1'b0, 1'b1, model(bpa[i], bpb[i], 1'b0));
    hold = model(bpa[0], bpb[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, bpa[4], bpb[4], 1'b0, 1'b0, model(bpa[4], bpb[4], 1'b0));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_c", 64'(c), 64'(hold[31:0]));
      chk("stall_co", 64'(co), 64'(hold[32]));
    end
    send(bpa[4], bpb[4], 1'b0);
    send(bpa[5], bpb[5], 1'b0);
    drain();
    chk("bp_count", 64'(n_out - n0), 64'd6);

    // Reset with two beats in flight.
    n0 = n_out;
    cycle(1'b1, 32'h00000005, 32'h00000007, 1'b0, 1'b1, model(32'h5, 32'h7, 1'b0));
    cycle(1'b1, 32'h00000100, 32'h00000200, 1'b1, 1'b1, model(32'h100, 32'h200, 1'b1));
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_c", 64'(c), 64'd0);
    chk("midrst_co", 64'(co), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    sbq.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 33'h0);
      chk("midrst_no_out", 64'(out_valid), 64'd0);
    end
    chk("midrst_count", 64'(n_out - n0), 64'd0);

    // Random traffic with random bubbles and backpressure.
    n_sent = 0;
    guard = 0;
    while (n_sent < 10000 && guard < 60000) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      ra   = $urandom;
      rb   = $urandom;
      rci  = 1'($urandom_range(0, 1));
      cycle(iv, ra, rb, rci, ordy, model(ra, rb, rci));
      if (acc_flag) n_sent++;
      guard++;
    end
    chk("random_sent", 64'(n_sent), 64'd10000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
